note_recorder: RTL and testbench
================================

Name: note_recorder

Overview:
- Capture-side counterpart of the automatic melody player. It samples the live 4-bit note code from the keyboard decoder on every quarter-beat tick and stores it in a small note memory.
- It replays the stored sequence on later ticks, using the same note encoding and the same quarter-beat timing as the player.
- It sits between the key decoder and the tone-generator mux. Its play_note output drives the same mux input as an auto-play note.

Parameters:
- DEPTH, 64, number of quarter-beat slots stored; must be a power of 2.
- AW, 6, address width, log2(DEPTH).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- QUARTER_BEAT_TICK  in  1  single-CLK-cycle pulse, one per quarter beat, synchronous to CLK.
- live_note  in  4  current key note code (NOTE_NONE when no key is pressed).
- rec_start  in  1  single-cycle pulse: arm recording.
- play_start  in  1  single-cycle pulse: start playback.
- stop  in  1  single-cycle pulse: abort the current operation.
- play_note  out  4  registered note code during playback; NOTE_NONE otherwise.
- rec_len  out  AW+1  number of stored slots, 0..DEPTH.
- busy  out  1  high in any state except IDLE.
- mode  out  2  current state encoding.
- full  out  1  high when rec_len == DEPTH.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, wr_ptr=0, rd_ptr=0, rec_len=0, play_note=NOTE_NONE, busy=0, full=0, mode=IDLE. Memory contents are don't-care.
- States and mode encoding: IDLE=0, ARMED=1, RECORD=2, PLAY=3.
- Command priority when pulses coincide: stop > rec_start > play_start. Commands in non-IDLE states:
  - stop in any state goes to IDLE the next cycle and sets play_note=NOTE_NONE; rec_len keeps the slots written so far.
  - rec_start and play_start are ignored unless the state is IDLE.
- IDLE + rec_start: rec_len<=0, wr_ptr<=0, go to ARMED. Leading silence is not recorded.
- ARMED:
  - On a tick with live_note==NOTE_NONE: stay in ARMED.
  - On a tick with live_note!=NOTE_NONE: mem[0]<=live_note, wr_ptr<=1, rec_len<=1, go to RECORD.
- RECORD: on each tick, mem[wr_ptr]<=live_note, wr_ptr++, rec_len++.
  - The write that makes rec_len==DEPTH also moves to IDLE in the same cycle and sets full=1.
  - The wr_ptr wrap to 0 is never used as an address.
- IDLE + play_start:
  - If rec_len==0: stay in IDLE, no output change.
  - Otherwise: rd_ptr<=0, go to PLAY. play_note stays NOTE_NONE until the first tick.
- PLAY: on each tick, if rd_ptr<rec_len then play_note<=mem[rd_ptr] and rd_ptr++.
  - On the tick where rd_ptr==rec_len: play_note<=NOTE_NONE and go to IDLE.
  - A sequence of N slots therefore produces exactly N notes, then silence on tick N+1.
- Latency: play_note changes on the CLK edge that samples the tick (1 CLK after the tick is asserted). Memory is asynchronous-read; no prefetch.
- A tick arriving in the same cycle as a state-entering command is not consumed by the new state.
- full clears on entry to ARMED.
- rec_len is cleared only by reset or rec_start, never by playback.

Optional Feature:
- Macro NOTE_RECORDER_LOOP_EN.
- Defined: in PLAY, the tick where rd_ptr==rec_len instead outputs mem[0], sets rd_ptr<=1 and stays in PLAY. Playback repeats seamlessly until stop.
- Undefined: single-pass playback as described under Behaviour.

Decomposition:
- Shared package (parameters.v):
  - 4-bit note codes, including NOTE_NONE=4'h0 and C4/D/E/F/G.
  - State encodings IDLE/ARMED/RECORD/PLAY.
- One sub-module: note_mem, a DEPTH x 4 RAM with synchronous write and asynchronous read (single write port, single read port).
- The FSM, pointers and output register stay in note_recorder.

Test Plan:
- Reset mid-PLAY:
  - Stimulus: assert RESET during PLAY.
  - Response: play_note=0, mode=0, rec_len=0 asynchronously, before the next CLK edge.
- Armed skip-silence:
  - Stimulus: rec_start; 3 ticks with live_note=0; then ticks with E,0,F; then stop.
  - Response: rec_len=3; playback yields E,0,F, then 0 on tick 4, and mode returns to 0.
- Fill to full:
  - Stimulus: rec_start, then 70 ticks with live_note=G.
  - Response: after tick 64, mode=0, full=1, rec_len=64; extra ticks cause no change.
- Empty play:
  - Stimulus: play_start after reset.
  - Response: mode stays 0, busy=0, play_note=0.
- Simultaneous commands:
  - Stimulus: rec_start and play_start in the same cycle while IDLE with rec_len=5.
  - Response: mode=1 and rec_len=0.
  - Stimulus: stop together with a tick in PLAY.
  - Response: mode=0 and play_note=0.
- Loop build (NOTE_RECORDER_LOOP_EN defined):
  - Stimulus: record C4,D; play for 6 ticks.
  - Response: play_note sequence C4,D,C4,D,C4,D, and mode stays 3.

Source files
------------

// File: rtl/note_recorder_pkg.sv
// Shared note codes and recorder state encodings for the note recorder.
package note_recorder_pkg;

  typedef logic [3:0] note_t;

  localparam note_t NOTE_NONE = 4'h0;
  localparam note_t NOTE_C4   = 4'h1;
  localparam note_t NOTE_D    = 4'h2;
  localparam note_t NOTE_E    = 4'h3;
  localparam note_t NOTE_F    = 4'h4;
  localparam note_t NOTE_G    = 4'h5;
  localparam note_t NOTE_A    = 4'h6;
  localparam note_t NOTE_B    = 4'h7;
  localparam note_t NOTE_C5   = 4'h8;

  // Encoding is visible on the mode output, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RECORD = 2'd2,
    ST_PLAY   = 2'd3
  } state_t;

endpackage

// File: rtl/note_recorder_mem.sv
// DEPTH x 4 note memory: synchronous write, asynchronous read.
module note_recorder_mem
  import note_recorder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  note_t         wdata,
  input  logic [AW-1:0] raddr,
  output note_t         rdata
);

  note_t mem [DEPTH];

  // NOTE: the array has no reset; contents are only read below rec_len, so
  // every slot is written before it is ever observed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/note_recorder.sv
// Records live notes on quarter-beat ticks and replays them in the same timing.
// Define NOTE_RECORDER_LOOP_EN to make playback repeat until stop.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          QUARTER_BEAT_TICK,
  input  note_t         live_note,
  input  logic          rec_start,
  input  logic          play_start,
  input  logic          stop,
  output note_t         play_note,
  output logic [AW:0]   rec_len,
  output logic          busy,
  output logic [1:0]    mode,
  output logic          full
);

  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LEN  = (AW+1)'(1);

  state_t        state, state_d;
  logic [AW-1:0] wr_ptr, wr_ptr_d;
  logic [AW:0]   rd_ptr, rd_ptr_d;
  logic [AW:0]   rec_len_d;
  note_t         play_note_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  note_t         mem_wdata;
  logic [AW-1:0] mem_raddr;
  note_t         mem_rdata;

  note_recorder_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

`ifdef NOTE_RECORDER_LOOP_EN
  // The end-of-sequence tick restarts from slot 0 instead of going silent.
  assign mem_raddr = (rd_ptr == rec_len) ? '0 : rd_ptr[AW-1:0];
`else
  assign mem_raddr = rd_ptr[AW-1:0];
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state;
    wr_ptr_d    = wr_ptr;
    rd_ptr_d    = rd_ptr;
    rec_len_d   = rec_len;
    play_note_d = play_note;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr;
    mem_wdata   = live_note;

    // Case is on the current state, so a tick coinciding with an entering
    // command is never consumed by the state being entered.
    if (stop) begin
      state_d     = ST_IDLE;
      play_note_d = NOTE_NONE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rec_start) begin
            rec_len_d = '0;
            wr_ptr_d  = '0;
            state_d   = ST_ARMED;
          end else if (play_start && (rec_len != '0)) begin
            rd_ptr_d = '0;
            state_d  = ST_PLAY;
          end
        end

        ST_ARMED: begin
          if (QUARTER_BEAT_TICK && (live_note != NOTE_NONE)) begin
            mem_we    = 1'b1;
            mem_waddr = '0;
            wr_ptr_d  = AW'(1);
            rec_len_d = ONE_LEN;
            state_d   = ST_RECORD;
          end
        end

        ST_RECORD: begin
          if (QUARTER_BEAT_TICK) begin
            mem_we    = 1'b1;
            wr_ptr_d  = wr_ptr + AW'(1);
            rec_len_d = rec_len + ONE_LEN;
            if (rec_len + ONE_LEN == FULL_LEN) state_d = ST_IDLE;
          end
        end

        ST_PLAY: begin
          if (QUARTER_BEAT_TICK) begin
            if (rd_ptr < rec_len) begin
              play_note_d = mem_rdata;
              rd_ptr_d    = rd_ptr + ONE_LEN;
            end else begin
`ifdef NOTE_RECORDER_LOOP_EN
              play_note_d = mem_rdata;
              rd_ptr_d    = ONE_LEN;
`else
              play_note_d = NOTE_NONE;
              state_d     = ST_IDLE;
`endif
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rec_len   <= '0;
      play_note <= NOTE_NONE;
    end else begin
      state     <= state_d;
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      rec_len   <= rec_len_d;
      play_note <= play_note_d;
    end
  end

  assign busy = (state != ST_IDLE);
  assign mode = state;
  assign full = (rec_len == FULL_LEN);

endmodule

// File: tb/tb_note_recorder.sv
// Directed self-checking bench for note_recorder (single-pass or looping build).
module tb_note_recorder;
  import note_recorder_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        QUARTER_BEAT_TICK;
  note_t       live_note;
  logic        rec_start;
  logic        play_start;
  logic        stop;
  note_t       play_note;
  logic [AW:0] rec_len;
  logic        busy;
  logic [1:0]  mode;
  logic        full;

  int checks = 0;
  int errors = 0;

  note_recorder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .QUARTER_BEAT_TICK (QUARTER_BEAT_TICK),
    .live_note         (live_note),
    .rec_start         (rec_start),
    .play_start        (play_start),
    .stop              (stop),
    .play_note         (play_note),
    .rec_len           (rec_len),
    .busy              (busy),
    .mode              (mode),
    .full              (full)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs from a falling edge; return at the next falling
  // edge, after the DUT has sampled them, with all pulses cleared.
  task automatic cycle(input logic tk, input note_t n, input logic rs,
                       input logic ps, input logic sp);
    @(negedge CLK);
    QUARTER_BEAT_TICK = tk;
    live_note         = n;
    rec_start         = rs;
    play_start        = ps;
    stop              = sp;
    @(negedge CLK);
    QUARTER_BEAT_TICK = 1'b0;
    rec_start         = 1'b0;
    play_start        = 1'b0;
    stop              = 1'b0;
  endtask

  task automatic tick(input note_t n);
    cycle(1'b1, n, 1'b0, 1'b0, 1'b0);
  endtask

  note_t skip_in  [6] = '{NOTE_NONE, NOTE_NONE, NOTE_NONE, NOTE_E, NOTE_NONE, NOTE_F};
  note_t skip_out [4] = '{NOTE_E, NOTE_NONE, NOTE_F, NOTE_NONE};
  note_t five     [5] = '{NOTE_C4, NOTE_D, NOTE_E, NOTE_F, NOTE_G};

  initial begin
    RESET = 1'b1;
    QUARTER_BEAT_TICK = 1'b0;
    live_note = NOTE_NONE;
    rec_start = 1'b0;
    play_start = 1'b0;
    stop = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_mode", mode, 0);
    check("rst_busy", busy, 0);
    check("rst_len", rec_len, 0);
    check("rst_note", play_note, NOTE_NONE);
    check("rst_full", full, 0);
    RESET = 1'b0;

    // Empty play is ignored.
    cycle(1'b0, NOTE_NONE, 1'b0, 1'b1, 1'b0);
    check("empty_mode", mode, 0);
    check("empty_busy", busy, 0);
    check("empty_note", play_note, NOTE_NONE);

    // Leading silence skipped, inner silence kept.
    cycle(1'b0, NOTE_NONE, 1'b1, 1'b0, 1'b0);
    check("arm_mode", mode, 1);
    check("arm_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      tick(skip_in[i]);
      if (i == 2) check("skip_still_armed", mode, 1);
      if (i == 3) check("skip_first_len", rec_len, 1);
    end
    check("skip_rec_mode", mode, 2);
    cycle(1'b0, NOTE_NONE, 1'b0, 1'b0, 1'b1);
    check("skip_stop_mode", mode, 0);
    check("skip_len", rec_len, 3);
    cycle(1'b0, NOTE_NONE, 1'b0, 1'b1, 1'b0);
    check("play_enter_mode", mode, 3);
    check("play_enter_note", play_note, NOTE_NONE);
    for (int i = 0; i < 4; i++) begin
      tick(NOTE_NONE);
`ifdef NOTE_RECORDER_LOOP_EN
      check($sformatf("skip_play%0d", i), play_note, (i == 3) ? NOTE_E : skip_out[i]);
`else
      check($sformatf("skip_play%0d", i), play_note, skip_out[i]);
`endif
    end
`ifdef NOTE_RECORDER_LOOP_EN
    check("skip_end_mode", mode, 3);
    cycle(1'b0, NOTE_NONE, 1'b0, 1'b0, 1'b1);
`else
    check("skip_end_mode", mode, 0);
`endif
    check("skip_keep_len", rec_len, 3);

    // Fill to full; extra ticks are ignored.
    cycle(1'b0, NOTE_NONE, 1'b1, 1'b0, 1'b0);
    check("fill_full_clr", full, 0);
    for (int i = 1; i <= 70; i++) begin
      tick(NOTE_G);
      if (i == 63) begin
        check("fill63_mode", mode, 2);
        check("fill63_full", full, 0);
      end
      if (i == 64) begin
        check("fill64_mode", mode, 0);
        check("fill64_full", full, 1);
        check("fill64_len", rec_len, 64);
      end
    end
    check("fill70_mode", mode, 0);
    check("fill70_full", full, 1);
    check("fill70_len", rec_len, 64);
    cycle(1'b0, NOTE_NONE, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      tick(NOTE_NONE);
      check($sformatf("full_play%0d", i), play_note, NOTE_G);
    end
    tick(NOTE_NONE);
`ifdef NOTE_RECORDER_LOOP_EN
    check("full_wrap_note", play_note, NOTE_G);
    check("full_wrap_mode", mode, 3);
    cycle(1'b0, NOTE_NONE, 1'b0, 1'b0, 1'b1);
`else
    check("full_end_note", play_note, NOTE_NONE);
    check("full_end_mode", mode, 0);
`endif
    check("full_keep", full, 1);

    // Five-slot take, then coincident commands.
    cycle(1'b0, NOTE_NONE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(five[i]);
    cycle(1'b0, NOTE_NONE, 1'b0, 1'b0, 1'b1);
    check("five_len", rec_len, 5);
    cycle(1'b0, NOTE_NONE, 1'b1, 1'b0, 1'b1);
    check("stop_beats_rec_mode", mode, 0);
    check("stop_beats_rec_len", rec_len, 5);
    cycle(1'b0, NOTE_NONE, 1'b1, 1'b1, 1'b0);
    check("rec_beats_play_mode", mode, 1);
    check("rec_beats_play_len", rec_len, 0);
    // Tick coinciding with rec_start was not consumed by ARMED.
    cycle(1'b1, NOTE_C4, 1'b0, 1'b0, 1'b0);
    check("c4_first_len", rec_len, 1);
    tick(NOTE_D);
    cycle(1'b0, NOTE_NONE, 1'b0, 1'b0, 1'b1);
    check("two_len", rec_len, 2);
    cycle(1'b1, NOTE_NONE, 1'b0, 1'b1, 1'b0);
    check("play_tick_same_note", play_note, NOTE_NONE);
    tick(NOTE_NONE);
    check("stoptick_pre", play_note, NOTE_C4);
    cycle(1'b1, NOTE_NONE, 1'b0, 1'b0, 1'b1);
    check("stoptick_mode", mode, 0);
    check("stoptick_note", play_note, NOTE_NONE);

    // Two-slot playback: looping or single pass.
    cycle(1'b0, NOTE_NONE, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(NOTE_NONE);
`ifdef NOTE_RECORDER_LOOP_EN
      check($sformatf("loop_note%0d", i), play_note, (i % 2 == 0) ? NOTE_C4 : NOTE_D);
      check($sformatf("loop_mode%0d", i), mode, 3);
`else
      if (i < 3)
        check($sformatf("once_note%0d", i), play_note,
              (i == 0) ? NOTE_C4 : ((i == 1) ? NOTE_D : NOTE_NONE));
`endif
    end
`ifndef NOTE_RECORDER_LOOP_EN
    check("once_mode", mode, 0);
`endif

    // Reset mid-play is seen before the next clock edge.
    cycle(1'b0, NOTE_NONE, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, NOTE_NONE, 1'b0, 1'b1, 1'b0);
    tick(NOTE_NONE);
    check("prerst_note", play_note, NOTE_C4);
    check("prerst_mode", mode, 3);
    #1 RESET = 1'b1;
    #1;
    check("async_rst_note", play_note, NOTE_NONE);
    check("async_rst_mode", mode, 0);
    check("async_rst_len", rec_len, 0);
    @(negedge CLK);
    RESET = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
